// File: rtl/pwm_audio_out.sv
// PWM audio sink: synchronises the enable, buffers one sample behind a ready/valid handshake and
// drives a 1-bit PWM output with soft start/stop duty ramps and underrun counting.
module pwm_audio_out #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned RAMP_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              pwm_out,
    output logic              amp_en,
    output logic [7:0]        underrun_cnt
);

    typedef enum logic [1:0] {
        StOff,
        StRampUp,
        StRun,
        StRampDown
    } state_e;

    localparam logic [DATA_W-1:0] CntMax  = '1;
    localparam logic [DATA_W:0]   DutyMid = (DATA_W + 1)'(2 ** (DATA_W - 1));
    localparam logic [DATA_W:0]   StepW   = (DATA_W + 1)'(RAMP_STEP);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   duty_q, duty_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                full_q, full_d;
    logic [7:0]          underrun_q, underrun_d;
    logic                pwm_q, pwm_d;
    logic                en_meta_q, en_s_q;

    logic                wrap;
    logic                accept;
    logic [DATA_W:0]     duty_up;
    logic [DATA_W-1:0]   duty_dn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StOff;
            cnt_q      <= '0;
            duty_q     <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            underrun_q <= '0;
            pwm_q      <= 1'b0;
            en_meta_q  <= 1'b0;
            en_s_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            underrun_q <= underrun_d;
            pwm_q      <= pwm_d;
            en_meta_q  <= en;
            en_s_q     <= en_meta_q;
        end
    end

    assign wrap         = (state_q != StOff) && (cnt_q == CntMax);
    assign sample_ready = (state_q == StRun) && !full_q;
    assign accept       = sample_valid && sample_ready;
    assign duty_up      = {1'b0, duty_q} + StepW;

    always_comb begin
        duty_dn = '0;
        if ({1'b0, duty_q} > StepW) begin
            duty_dn = duty_q - StepW[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + DATA_W'(1);
        duty_d     = duty_q;
        hold_d     = hold_q;
        full_d     = full_q;
        underrun_d = underrun_q;

        if (accept) begin
            hold_d = sample;
            full_d = 1'b1;
        end

        unique case (state_q)
            StOff: begin
                cnt_d  = '0;
                duty_d = '0;
                full_d = 1'b0;
                if (en_s_q) begin
                    state_d = StRampUp;
                end
            end
            StRampUp: begin
                if (wrap) begin
                    if (!en_s_q) begin
                        state_d = StRampDown;
                    end else if (duty_up >= DutyMid) begin
                        duty_d  = DutyMid[DATA_W-1:0];
                        state_d = StRun;
                    end else begin
                        duty_d = duty_up[DATA_W-1:0];
                    end
                end
            end
            StRun: begin
                if (wrap) begin
                    if (!en_s_q) begin
                        // Pending sample is dropped so a later RUN never plays stale audio.
                        state_d = StRampDown;
                        full_d  = 1'b0;
                    end else if (full_q) begin
                        duty_d = hold_q;
                        full_d = 1'b0;
                    end else if (underrun_q != 8'hFF) begin
                        underrun_d = underrun_q + 8'd1;
                    end
                end
            end
            StRampDown: begin
                if (wrap) begin
                    if (en_s_q) begin
                        state_d = StRampUp;
                    end else if (duty_dn == '0) begin
                        duty_d  = '0;
                        state_d = StOff;
                    end else begin
                        duty_d = duty_dn;
                    end
                end
            end
            default: state_d = StOff;
        endcase

        pwm_d = (state_q != StOff) && (cnt_q < duty_q);
    end

    assign pwm_out      = pwm_q;
    assign amp_en       = (state_q != StOff);
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out: expected PWM pulse widths are queued as each period is driven
// and a pulse monitor pops and compares them as pwm_out pulses complete.
module tb_pwm_audio_out;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] sample;
    logic       sample_valid;
    logic       sample_ready;
    logic       pwm_out;
    logic       amp_en;
    logic [7:0] underrun_cnt;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int run_len = 0;

    pwm_audio_out dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pwm_out      (pwm_out),
        .amp_en       (amp_en),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are read 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input int d);
        if (d != 0) exp_q.push_back(d);
    endtask

    task automatic run_period(input int d);
        expect_pulse(d);
        step(256);
    endtask

    task automatic send(input logic [7:0] s);
        sample       = s;
        sample_valid = 1'b1;
        step(1);
        sample_valid = 1'b0;
    endtask

    // Pulse monitor: each completed high run of pwm_out is one period's duty.
    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
        end else if (pwm_out === 1'b1) begin
            run_len++;
        end else if (run_len != 0) begin
            if (exp_q.size() == 0) begin
                chk("pulse_unexpected", run_len, 0);
            end else begin
                chk("pulse_width", run_len, exp_q.pop_front());
            end
            run_len = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        sample       = '0;
        sample_valid = 1'b0;
        step(3);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_amp_en", amp_en, 0);
        chk("rst_ready", sample_ready, 0);
        chk("rst_underrun", underrun_cnt, 0);
        rst = 1'b0;
        step(2);
        chk("off_amp_en", amp_en, 0);

        // Enable: amp_en after exactly 3 clocks.
        en = 1'b1;
        step(2);
        chk("amp_en_early", amp_en, 0);
        step(1);
        chk("amp_en_on", amp_en, 1);
        chk("ready_rampup", sample_ready, 0);
        step(256);
        for (int w = 1; w <= 51; w++) run_period(w);

        // Drop enable at duty 52, reverse at duty 50.
        expect_pulse(52);
        step(10);
        en = 1'b0;
        step(246);
        run_period(52);
        chk("amp_en_rampdown", amp_en, 1);
        chk("ready_rampdown", sample_ready, 0);
        run_period(51);
        expect_pulse(50);
        step(10);
        en = 1'b1;
        step(246);
        run_period(50);
        for (int w = 51; w <= 127; w++) run_period(w);

        // RUN with duty 128, empty buffer.
        chk("ready_run", sample_ready, 1);
        chk("underrun_run_entry", underrun_cnt, 0);
        run_period(128);
        chk("underrun_1", underrun_cnt, 1);
        run_period(128);
        chk("underrun_2", underrun_cnt, 2);

        expect_pulse(128);
        send(8'h40);
        chk("ready_after_accept", sample_ready, 0);
        step(255);
        chk("ready_after_consume", sample_ready, 1);
        chk("underrun_fed_40", underrun_cnt, 2);
        expect_pulse(64);
        send(8'hC0);
        step(255);
        chk("underrun_fed_c0", underrun_cnt, 2);

        // Sample offered exactly in the wrap cycle with an empty buffer.
        expect_pulse(192);
        step(255);
        chk("ready_at_wrap", sample_ready, 1);
        send(8'hC8);
        chk("underrun_wrap_sample", underrun_cnt, 3);
        chk("ready_wrap_sample", sample_ready, 0);
        run_period(192);

        // Pending sample dropped on disable; quick re-enable clamps 199 to 128.
        expect_pulse(200);
        send(8'h10);
        en = 1'b0;
        step(255);
        chk("ready_drop", sample_ready, 0);
        chk("amp_en_drop", amp_en, 1);
        run_period(200);
        expect_pulse(199);
        step(10);
        en = 1'b1;
        step(246);
        run_period(199);
        chk("ready_after_discard", sample_ready, 1);
        run_period(128);
        chk("underrun_after_discard", underrun_cnt, 4);

        // Small duty then ramp all the way down to OFF.
        expect_pulse(128);
        send(8'h08);
        step(255);
        expect_pulse(8);
        step(10);
        en = 1'b0;
        step(246);
        for (int d = 8; d >= 1; d--) run_period(d);
        chk("off_amp_en_after_ramp", amp_en, 0);
        chk("off_pwm_after_ramp", pwm_out, 0);
        chk("off_ready", sample_ready, 0);
        chk("underrun_kept", underrun_cnt, 4);
        step(300);
        chk("off_amp_en_stays", amp_en, 0);

        // Second ramp to RUN, then reset mid-period with pwm high.
        en = 1'b1;
        step(3);
        chk("amp_en_second", amp_en, 1);
        step(256);
        for (int w = 1; w <= 127; w++) run_period(w);
        run_period(128);
        chk("underrun_second_run", underrun_cnt, 5);
        step(60);
        chk("pwm_high_before_rst", pwm_out, 1);
        rst = 1'b1;
        #1;
        chk("midrst_pwm", pwm_out, 0);
        chk("midrst_amp_en", amp_en, 0);
        chk("midrst_ready", sample_ready, 0);
        chk("midrst_underrun", underrun_cnt, 0);
        step(3);
        en  = 1'b0;
        rst = 1'b0;
        step(10);
        chk("post_rst_amp_en", amp_en, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
